mem_wb_pipe: RTL and testbench

//  Parametrised, elastic MEM->WB pipeline register: DEPTH back-to-back skid stages carrying
//  {RegWrite, MemtoReg, RDaddr, ALU result, memory data} with valid/ready flow control,

---
 rtl/mem_wb_pipe_pkg.sv | 46 ++++
 rtl/mem_wb_pipe_skid.sv | 87 ++++++++
 rtl/mem_wb_pipe.sv | 111 +++++++++++
 tb/tb_mem_wb_pipe.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe_pkg
//   Shared definitions for the MEM->WB elastic pipeline register.
//   - skid_state_t  : occupancy of one elastic stage (main slot / main+skid)
//   - payload_w()   : packed payload width {RegWrite, MemtoReg, RDaddr, ALU, Mem}
//   - off_*()       : bit offsets of each field inside the packed payload
//   Field layout, MSB to LSB:
//     [off_rw]             RegWrite
//     [off_m2r]            MemtoReg
//     [off_rd  +: ADDR_W]  RDaddr
//     [off_alu +: DATA_W]  ALU result
//     [off_mem +: DATA_W]  memory read data
// -----------------------------------------------------------------------------
package mem_wb_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    function automatic int payload_w(input int data_w, input int addr_w);
        return 2 + addr_w + 2 * data_w;
    endfunction

    function automatic int off_mem();
        return 0;
    endfunction

    function automatic int off_alu(input int data_w);
        return data_w;
    endfunction

    function automatic int off_rd(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int off_m2r(input int data_w, input int addr_w);
        return 2 * data_w + addr_w;
    endfunction

    function automatic int off_rw(input int data_w, input int addr_w);
        return 2 * data_w + addr_w + 1;
    endfunction

endpackage

// File: rtl/mem_wb_pipe_skid.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//   One elastic pipeline stage with a main slot and a skid slot.
//   Occupancy: EMPTY -> ONE (main valid) -> FULL (main + skid valid).
//   ready is derived only from registered state (never from out_ready), so
//   chaining stages builds no combinational ready path.
// Ports
//   clk, rst   clock, async active-high reset
//   en         run enable; 0 holds state and payload exactly
//   flush      clears both valid bits at the next edge (beats en)
//   in_valid   upstream has an entry
//   in_data    upstream payload
//   ready      stage can take an entry this cycle (skid slot free)
//   out_ready  downstream takes the main-slot entry this cycle
//   out_valid  main slot holds an entry
//   out_data   main-slot payload (stale when out_valid = 0)
// -----------------------------------------------------------------------------
module pipe_skid_stage
    import mem_wb_pipe_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [PW-1:0] in_data,
    output logic          ready,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [PW-1:0] out_data
);

    skid_state_t   state;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic          push;
    logic          pop;

    assign ready     = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_q;

    assign push = en & in_valid & ready;
    assign pop  = en & out_ready & out_valid;

    // Payload registers only load on a push (or skid->main on pop from FULL);
    // an empty slot keeps stale data, masked by the valid state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        main_q <= in_data;
                        state  <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_q <= in_data;
                    end else if (push) begin
                        skid_q <= in_data;
                        state  <= ST_FULL;
                    end else if (pop) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // ready is low here, so no push can coincide with the pop
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe
//   Elastic MEM->WB pipeline register: DEPTH chained skid stages carrying
//   {RegWrite, MemtoReg, RDaddr, ALU result, memory data}, with valid/ready
//   flow control, cache-miss stall, run enable, flush and per-stage
//   forwarding taps for the hazard/forwarding unit.
// Parameters
//   DATA_W  ALU result / memory data width
//   ADDR_W  register-file address width
//   DEPTH   number of elastic stages (1..4) = empty-pipe latency in cycles
// Ports
//   clk_i, rst_i           clock, async active-high reset
//   start_i, cpu_stall_i   run enable / cache-miss stall (either freezes all)
//   flush_i                kill every in-flight entry at the next edge
//   in_valid_i/in_ready_o  upstream handshake
//   RegWrite_i .. Mem_data_i  incoming payload
//   out_valid_o/out_ready_i   write-back handshake
//   RegWrite_o             write strobe: delivered entry with RegWrite set
//   RDaddr_o, WB_data_o    last-stage destination and selected write-back value
//   fwd_valid_o/rd/data    per-stage main-slot taps, stage k at slice k
// -----------------------------------------------------------------------------
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    cpu_stall_i,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    RegWrite_i,
    input  logic                    MemtoReg_i,
    input  logic [ADDR_W-1:0]       RDaddr_i,
    input  logic [DATA_W-1:0]       ALU_Result_i,
    input  logic [DATA_W-1:0]       Mem_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    RegWrite_o,
    output logic [ADDR_W-1:0]       RDaddr_o,
    output logic [DATA_W-1:0]       WB_data_o,
    output logic [DEPTH-1:0]        fwd_valid_o,
    output logic [DEPTH*ADDR_W-1:0] fwd_rd_o,
    output logic [DEPTH*DATA_W-1:0] fwd_data_o
);

    localparam int PW      = payload_w(DATA_W, ADDR_W);
    localparam int OFF_MEM = off_mem();
    localparam int OFF_ALU = off_alu(DATA_W);
    localparam int OFF_RD  = off_rd(DATA_W);
    localparam int OFF_M2R = off_m2r(DATA_W, ADDR_W);
    localparam int OFF_RW  = off_rw(DATA_W, ADDR_W);

    logic          active;
    logic [PW-1:0] in_pl;
    logic [PW-1:0] last_pl;

    // Link k connects stage k-1 (producer) to stage k (consumer);
    // link 0 is the upstream port, link DEPTH is the write-back port.
    logic [DEPTH:0] lnk_valid;
    logic [DEPTH:0] lnk_ready;
    logic [PW-1:0]  lnk_data [DEPTH+1];

    assign active = start_i & ~cpu_stall_i;
    assign in_pl  = {RegWrite_i, MemtoReg_i, RDaddr_i, ALU_Result_i, Mem_data_i};

    assign lnk_valid[0]     = in_valid_i;
    assign lnk_data[0]      = in_pl;
    assign lnk_ready[DEPTH] = out_ready_i;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_skid_stage #(
            .PW(PW)
        ) u_stage (
            .clk       (clk_i),
            .rst       (rst_i),
            .en        (active),
            .flush     (flush_i),
            .in_valid  (lnk_valid[k]),
            .in_data   (lnk_data[k]),
            .ready     (lnk_ready[k]),
            .out_ready (lnk_ready[k+1]),
            .out_valid (lnk_valid[k+1]),
            .out_data  (lnk_data[k+1])
        );

        // Forwarding taps look at the main slot only: it holds the oldest
        // entry of the stage, which is the one the hazard unit must see.
        assign fwd_valid_o[k] = lnk_valid[k+1] & lnk_data[k+1][OFF_RW];
        assign fwd_rd_o[k*ADDR_W +: ADDR_W] = lnk_data[k+1][OFF_RD +: ADDR_W];
        assign fwd_data_o[k*DATA_W +: DATA_W] = lnk_data[k+1][OFF_M2R]
                                              ? lnk_data[k+1][OFF_MEM +: DATA_W]
                                              : lnk_data[k+1][OFF_ALU +: DATA_W];
    end

    assign last_pl = lnk_data[DEPTH];

    // Handshake outputs are masked while frozen; the flush cycle never
    // presents a deliverable entry, so no write-back can slip through it.
    assign in_ready_o  = active & ~rst_i & lnk_ready[0];
    assign out_valid_o = active & ~flush_i & lnk_valid[DEPTH];
    assign RegWrite_o  = out_valid_o & out_ready_i & last_pl[OFF_RW];
    assign RDaddr_o    = last_pl[OFF_RD +: ADDR_W];
    assign WB_data_o   = last_pl[OFF_M2R] ? last_pl[OFF_MEM +: DATA_W]
                                          : last_pl[OFF_ALU +: DATA_W];

endmodule

// File: tb/tb_mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_pipe
//   Drives three mem_wb_pipe instances (DEPTH = 1, 2, 3) with shared random
//   stimulus and compares every cycle against a queue-per-stage model.
// -----------------------------------------------------------------------------
module tb_mem_wb_pipe;

    localparam int NI = 3;   // instance g has DEPTH = g+1

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mem;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;

    logic [NI-1:0]         in_ready_a;
    logic [NI-1:0]         out_valid_a;
    logic [NI-1:0]         regwrite_a;
    logic [NI-1:0][4:0]    rd_a;
    logic [NI-1:0][31:0]   wb_a;
    logic [NI-1:0][3:0]    fv_a;
    logic [NI-1:0][19:0]   frd_a;
    logic [NI-1:0][127:0]  fdata_a;

    int n_total = 0;
    int n_bad   = 0;

    // model: one queue per stage, index g*4 + k, capacity 2 each
    ent_t mq [NI*4][$];

    int acc_d2;
    int cyc_no;
    int first_d1;
    int first_d3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int D = g + 1;
        logic [D-1:0]    fv;
        logic [D*5-1:0]  frd;
        logic [D*32-1:0] fd;
        logic            ir, ov, rwo;
        logic [4:0]      rdo;
        logic [31:0]     wbo;

        mem_wb_pipe #(
            .DATA_W(32),
            .ADDR_W(5),
            .DEPTH (D)
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .start_i      (start),
            .cpu_stall_i  (stall),
            .flush_i      (flush),
            .in_valid_i   (in_valid),
            .in_ready_o   (ir),
            .RegWrite_i   (rw),
            .MemtoReg_i   (m2r),
            .RDaddr_i     (rd),
            .ALU_Result_i (alu),
            .Mem_data_i   (mem),
            .out_valid_o  (ov),
            .out_ready_i  (out_ready),
            .RegWrite_o   (rwo),
            .RDaddr_o     (rdo),
            .WB_data_o    (wbo),
            .fwd_valid_o  (fv),
            .fwd_rd_o     (frd),
            .fwd_data_o   (fd)
        );

        assign in_ready_a[g]  = ir;
        assign out_valid_a[g] = ov;
        assign regwrite_a[g]  = rwo;
        assign rd_a[g]        = rdo;
        assign wb_a[g]        = wbo;
        assign fv_a[g]        = 4'(fv);
        assign frd_a[g]       = 20'(frd);
        assign fdata_a[g]     = 128'(fd);
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] wb_of(input ent_t e);
        return e.m2r ? e.mem : e.alu;
    endfunction

    function automatic ent_t cur_entry();
        ent_t e;
        e.rw  = rw;
        e.m2r = m2r;
        e.rd  = rd;
        e.alu = alu;
        e.mem = mem;
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NI*4; i++) mq[i].delete();
    endtask

    // Expected outputs from the model's current contents and present inputs.
    task automatic check_outputs();
        logic act;
        act = start & ~stall;
        for (int g = 0; g < NI; g++) begin
            int   d;
            int   lq;
            logic exp_ir, exp_ov, exp_rw;
            logic [3:0] exp_fv;
            d  = g + 1;
            lq = g*4 + d - 1;
            exp_ir = act & (mq[g*4].size() < 2);
            exp_ov = act & ~flush & (mq[lq].size() > 0);
            exp_rw = 1'b0;
            if (mq[lq].size() > 0) exp_rw = exp_ov & out_ready & mq[lq][0].rw;
            check_eq($sformatf("in_ready d%0d", d), 128'(in_ready_a[g]), 128'(exp_ir));
            check_eq($sformatf("out_valid d%0d", d), 128'(out_valid_a[g]), 128'(exp_ov));
            check_eq($sformatf("RegWrite_o d%0d", d), 128'(regwrite_a[g]), 128'(exp_rw));
            if (mq[lq].size() > 0) begin
                check_eq($sformatf("RDaddr_o d%0d", d), 128'(rd_a[g]), 128'(mq[lq][0].rd));
                check_eq($sformatf("WB_data_o d%0d", d), 128'(wb_a[g]), 128'(wb_of(mq[lq][0])));
            end
            exp_fv = '0;
            for (int k = 0; k < d; k++) begin
                int qi;
                qi = g*4 + k;
                if (mq[qi].size() > 0) begin
                    exp_fv[k] = mq[qi][0].rw;
                    check_eq($sformatf("fwd_rd d%0d s%0d", d, k),
                             128'(frd_a[g][k*5 +: 5]), 128'(mq[qi][0].rd));
                    check_eq($sformatf("fwd_data d%0d s%0d", d, k),
                             128'(fdata_a[g][k*32 +: 32]), 128'(wb_of(mq[qi][0])));
                end
            end
            check_eq($sformatf("fwd_valid d%0d", d), 128'(fv_a[g]), 128'(exp_fv));
        end
    endtask

    // Advance the model by one clock edge using the present inputs.
    task automatic model_step();
        logic act;
        act = start & ~stall;
        for (int g = 0; g < NI; g++) begin
            int   d;
            int   lq;
            logic mv [4];
            logic pop_last, push0;
            d  = g + 1;
            lq = g*4 + d - 1;
            if (flush) begin
                for (int k = 0; k < d; k++) mq[g*4 + k].delete();
            end else if (act) begin
                for (int k = 0; k < 4; k++) mv[k] = 1'b0;
                for (int k = 0; k < d - 1; k++)
                    mv[k] = (mq[g*4 + k].size() > 0) && (mq[g*4 + k + 1].size() < 2);
                pop_last = out_ready && (mq[lq].size() > 0);
                push0    = in_valid && (mq[g*4].size() < 2);
                if (pop_last) void'(mq[lq].pop_front());
                for (int k = d - 2; k >= 0; k--)
                    if (mv[k]) mq[g*4 + k + 1].push_back(mq[g*4 + k].pop_front());
                if (push0) mq[g*4].push_back(cur_entry());
            end
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #2;
        check_outputs();
        if (in_valid && in_ready_a[1] && !flush) acc_d2++;
        if (first_d1 < 0 && out_valid_a[0]) first_d1 = cyc_no;
        if (first_d3 < 0 && out_valid_a[2]) first_d3 = cyc_no;
        cyc_no++;
        model_step();
        @(negedge clk);
    endtask

    task automatic drive_rand(input int p_valid, input int p_ready, input int p_stall,
                              input int p_flush, input int p_stop);
        in_valid  = ($urandom_range(99) < p_valid);
        out_ready = ($urandom_range(99) < p_ready);
        stall     = ($urandom_range(99) < p_stall);
        flush     = ($urandom_range(99) < p_flush);
        start     = !($urandom_range(99) < p_stop);
        rw        = 1'($urandom);
        m2r       = 1'($urandom);
        rd        = 5'($urandom);
        alu       = $urandom;
        mem       = $urandom;
    endtask

    task automatic run(input int n, input int p_valid, input int p_ready, input int p_stall,
                       input int p_flush, input int p_stop);
        for (int i = 0; i < n; i++) begin
            drive_rand(p_valid, p_ready, p_stall, p_flush, p_stop);
            tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int g = 0; g < NI; g++) begin
            check_eq($sformatf("%s in_ready d%0d", tag, g+1), 128'(in_ready_a[g]), '0);
            check_eq($sformatf("%s out_valid d%0d", tag, g+1), 128'(out_valid_a[g]), '0);
            check_eq($sformatf("%s RegWrite_o d%0d", tag, g+1), 128'(regwrite_a[g]), '0);
            check_eq($sformatf("%s RDaddr_o d%0d", tag, g+1), 128'(rd_a[g]), '0);
            check_eq($sformatf("%s WB_data_o d%0d", tag, g+1), 128'(wb_a[g]), '0);
            check_eq($sformatf("%s fwd_valid d%0d", tag, g+1), 128'(fv_a[g]), '0);
            check_eq($sformatf("%s fwd_rd d%0d", tag, g+1), 128'(frd_a[g]), '0);
            check_eq($sformatf("%s fwd_data d%0d", tag, g+1), fdata_a[g], '0);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        rw = 1'b0; m2r = 1'b0; rd = '0; alu = '0; mem = '0;
        acc_d2 = 0; cyc_no = 0; first_d1 = -1; first_d3 = -1;
        model_clear();

        // reset state
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;

        // single directed push into the DEPTH=1 instance
        in_valid = 1'b1; out_ready = 1'b1;
        rw = 1'b1; m2r = 1'b0; rd = 5'd5; alu = 32'h1234; mem = 32'hDEAD_0000;
        tick();
        in_valid = 1'b0;
        #1;
        check_eq("t1 out_valid", 128'(out_valid_a[0]), 128'(1'b1));
        check_eq("t1 RegWrite_o", 128'(regwrite_a[0]), 128'(1'b1));
        check_eq("t1 RDaddr_o", 128'(rd_a[0]), 128'(5'd5));
        check_eq("t1 WB_data_o", 128'(wb_a[0]), 128'(32'h1234));
        tick();
        run(4, 0, 100, 0, 0, 0);

        // back-to-back stream: latency DEPTH, one per cycle
        cyc_no = 0; first_d1 = -1; first_d3 = -1;
        run(30, 100, 100, 0, 0, 0);
        check_eq("latency d1", 128'(first_d1), 128'(1));
        check_eq("latency d3", 128'(first_d3), 128'(3));
        run(6, 0, 100, 0, 0, 0);

        // blocked write-back: DEPTH=2 takes exactly 4 entries
        acc_d2 = 0;
        run(12, 100, 0, 0, 0, 0);
        check_eq("d2 accepted", 128'(acc_d2), 128'(4));
        run(10, 0, 100, 0, 0, 0);

        // stall-heavy traffic
        run(60, 60, 70, 35, 0, 0);
        run(8, 0, 100, 0, 0, 0);

        // flush with full pipes and simultaneous push/pop
        run(6, 100, 0, 0, 0, 0);
        run(1, 100, 100, 0, 100, 0);
        run(4, 0, 100, 0, 0, 0);

        // mixed random traffic
        run(300, 70, 70, 15, 3, 10);

        // asynchronous reset between edges while full
        run(6, 100, 0, 0, 0, 0);
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1 check_all_zero("async rst");
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        rw = 1'b1; m2r = 1'b1; rd = 5'd7; alu = 32'h0000_AAAA; mem = 32'h0000_BEEF;
        tick();
        in_valid = 1'b0;
        #1;
        check_eq("rst m2r WB_data_o", 128'(wb_a[0]), 128'(32'h0000_BEEF));
        tick();
        run(6, 0, 100, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
